nes_oam_dma: RTL
================

// Module: nes_oam_dma
// PURPOSE
// - Sprite DMA engine on the CPU-to-SRAM bus, between cpu6502 and the 64K memory controller.
// - A CPU write to $4014 starts a copy of page {data,8'h00}..{data,8'hFF} to the OAM data port ($2004).
// - The CPU is frozen through its clock enable while the copy runs.
// - Otherwise the block is a transparent bus mux: CPU address, data and write strobe pass straight to memory.
// PARAMETERS
// DMA_REG    16'h4014  CPU write address that starts a DMA
// OAM_DATA   16'h2004  destination address for every copied byte
// ALIGN_CYC  1         stall cycles before the first read (1..3)
// PORTS
// clock        in   1   system clock; memory runs on the same edge
// reset        in   1   synchronous, active-high
// cpu_address  in   16  CPU bus address
// cpu_o        in   8   CPU write data
// cpu_w        in   1   CPU write strobe
// cpu_ce       out  1   CPU clock enable; 0 = CPU frozen
// mem_address  out  16  address to SRAM/PPU bus
// mem_o        out  8   write data to bus
// mem_w        out  1   write strobe to bus
// mem_i        in   8   registered read data; valid the cycle after the address
// dma_busy     out  1   high while a DMA owns the bus
// dma_done     out  1   one-cycle pulse on the cycle after the last OAM write
// BEHAVIOUR
// - Reset values: state IDLE, idx=0, page=0, cpu_ce=1, dma_busy=0, dma_done=0, mem_w=0 while reset is high.
// - IDLE: mux passes CPU through (mem_address=cpu_address, mem_o=cpu_o, mem_w=cpu_w).
//   - cpu_w && cpu_address==DMA_REG latches page<=cpu_o and goes to HALT.
//   - The trigger write itself still reaches memory.
// - HALT: cpu_ce=0, dma_busy=1, mem_w=0; ALIGN_CYC cycles, then READ with idx=0.
// - READ: mem_address={page,idx}, mem_w=0, cpu_ce=0. Next state WRITE.
// - WRITE: mem_address=OAM_DATA, mem_o=mem_i (read result of the previous cycle), mem_w=1.
//   - If idx==8'hFF: go to IDLE and pulse dma_done next cycle.
//   - Otherwise: idx<=idx+1 (8-bit, no carry into page), back to READ.
// - Timing: cpu_ce is low for exactly ALIGN_CYC+512 cycles, starting the cycle after the trigger.
//   - 256 reads and 256 writes; bytes land in order idx 0..255.
// - Page FF: the source wraps inside $FF00-$FFFF and never crosses to $0000.
// - cpu_w or address activity while busy is ignored; a $4014 write while busy neither restarts nor re-latches.
// - Back-to-back: a $4014 write in the first IDLE cycle after done starts a new DMA normally.
// - Reset mid-DMA: IDLE next cycle, cpu_ce=1, no further bus writes, dma_done not pulsed.
// - Outputs cpu_ce, dma_busy and dma_done are registered.
//   - The bus mux is combinational from state/idx/page and the CPU inputs.
// STRUCTURE
// - Shared package nes_bus_pkg: DMA_REG/OAM_DATA address constants and the state enum {IDLE,HALT,READ,WRITE}.
//   - The PPU register decoder reuses them.
// - One always block for the FSM plus idx/page/align counters, one combinational bus mux.
// - No sub-module; the mux is too thin to split out.
// TESTING
// 1 Pass-through: CPU writes 8'h5A to $0300 -> mem_w=1, mem_address=$0300, mem_o=$5A, same cycle; cpu_ce stays 1.
// 2 Full DMA: SRAM $0200+i = i^8'hA5; CPU writes 8'h02 to $4014.
//   -> 256 writes to $2004 with data i^A5 in order; cpu_ce low 513 cycles (ALIGN_CYC=1); one dma_done pulse.
// 3 Page wrap: CPU writes 8'hFF -> reads $FF00..$FFFF only; no access to $0000 after $FFFF.
// 4 Reset at byte 100: assert reset 1 cycle -> next cycle cpu_ce=1, dma_busy=0, mem_w follows CPU, no dma_done.
// 5 Stray write while busy: force cpu_w=1, cpu_address=$4014, cpu_o=$07 mid-DMA -> page unchanged, count still 256.
// 6 Back-to-back: second $4014 write on the cycle after dma_done -> second DMA completes with its own page data.

Source files
------------

// File: rtl/nes_bus_pkg.sv
// Shared CPU/PPU bus definitions: register addresses and the sprite DMA state encoding.
package nes_bus_pkg;

   localparam logic [15:0] DMA_REG  = 16'h4014;
   localparam logic [15:0] OAM_DATA = 16'h2004;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HALT  = 2'd1,
      READ  = 2'd2,
      WRITE = 2'd3
   } dma_state_t;

endpackage : nes_bus_pkg

// File: rtl/nes_oam_dma.sv
// Sprite DMA engine. It sits between the CPU and the memory controller and is
// a plain pass-through mux until the CPU writes $4014. That write freezes the
// CPU and copies one 256-byte page, byte by byte, into the OAM data port.
//
// state | meaning
// IDLE  | CPU owns the bus; watch for a $4014 write
// HALT  | CPU frozen; alignment stall before the first read
// READ  | present source address {page,idx}
// WRITE | write last cycle's read data to OAM_DATA; advance idx
module nes_oam_dma
   import nes_bus_pkg::*;
#(
   parameter int unsigned ALIGN_CYC = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] cpu_address,
   input  logic [7:0]  cpu_o,
   input  logic        cpu_w,
   output logic        cpu_ce,
   output logic [15:0] mem_address,
   output logic [7:0]  mem_o,
   output logic        mem_w,
   input  logic [7:0]  mem_i,
   output logic        dma_busy,
   output logic        dma_done
);

   // Stall counter counts down to zero; loading ALIGN_CYC-1 gives ALIGN_CYC HALT cycles.
   localparam logic [1:0] ALIGN_INIT = 2'(ALIGN_CYC - 1);

   dma_state_t state;
   dma_state_t state_nxt;
   logic [7:0] idx;
   logic [7:0] page;
   logic [1:0] align_cnt;
   logic       trigger;

   assign trigger = cpu_w && (cpu_address == DMA_REG);

   // State register, transfer counters and the registered CPU-facing flags.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         idx       <= 8'h00;
         page      <= 8'h00;
         align_cnt <= 2'd0;
         cpu_ce    <= 1'b1;
         dma_busy  <= 1'b0;
         dma_done  <= 1'b0;
      end else begin
         state    <= state_nxt;
         cpu_ce   <= (state_nxt == IDLE);
         dma_busy <= (state_nxt != IDLE);
         dma_done <= (state == WRITE) && (idx == 8'hFF);
         case (state)
            IDLE: begin
               if (trigger) begin
                  page      <= cpu_o;
                  align_cnt <= ALIGN_INIT;
                  idx       <= 8'h00;
               end
            end
            HALT: begin
               idx <= 8'h00;
               if (align_cnt != 2'd0) begin
                  align_cnt <= align_cnt - 2'd1;
               end
            end
            WRITE: begin
               // 8-bit wrap: the source never carries out of the latched page.
               idx <= idx + 8'h01;
            end
            default: ;
         endcase
      end
   end

   // Next-state decode; a $4014 write is only honoured from IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (trigger) state_nxt = HALT;
         HALT:    if (align_cnt == 2'd0) state_nxt = READ;
         READ:    state_nxt = WRITE;
         WRITE:   state_nxt = (idx == 8'hFF) ? IDLE : READ;
         default: state_nxt = IDLE;
      endcase
   end

   // Bus mux: CPU pass-through in IDLE, DMA drives the bus otherwise; no writes during reset.
   always_comb begin
      mem_address = cpu_address;
      mem_o       = cpu_o;
      mem_w       = cpu_w;
      case (state)
         HALT: begin
            mem_address = {page, 8'h00};
            mem_o       = 8'h00;
            mem_w       = 1'b0;
         end
         READ: begin
            mem_address = {page, idx};
            mem_o       = 8'h00;
            mem_w       = 1'b0;
         end
         WRITE: begin
            mem_address = OAM_DATA;
            mem_o       = mem_i;
            mem_w       = 1'b1;
         end
         default: ;
      endcase
      if (reset) begin
         mem_w = 1'b0;
      end
   end

endmodule : nes_oam_dma
